alu_mc: RTL



---
 rtl/alu_mc.sv | 131 +++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU. Logic and add ops finish in one cycle. Shifts move the operand
// one bit per cycle, driven by a down-counter.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [2:0]       Op,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Cout,
  output logic             Z,
  output logic             N,
  output logic             P
);

  // state | meaning
  // IDLE  | no result held, ready for a request
  // SHIFT | shift in progress, one bit per cycle, cnt_q bits remaining
  // DONE  | result and flags valid, waiting for out_ready
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state_q;
  logic [WIDTH-1:0] res_q;
  logic             ofl_q;
  logic             cout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sop_q;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_d;
  logic             ofl_d;
  logic             cout_d;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;

  assign Out  = res_q;
  assign Ofl  = ofl_q;
  assign Cout = cout_q;
  assign Z    = (res_q == '0);
  assign N    = res_q[WIDTH-1];
  assign P    = ~Z & ~N;

  always_comb begin
    op_a   = invA ? ~A : A;
    op_b   = invB ? ~B : B;
    sum    = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, Cin};
    cnt_d  = op_b[CNT_W-1:0];
    res_d  = op_a;
    ofl_d  = 1'b0;
    cout_d = 1'b0;
    case (Op)
      3'b100: begin
        res_d  = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
        ofl_d  = sign ? ((op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]))
                      : sum[WIDTH];
      end
      3'b101:  res_d = op_a | op_b;
      3'b110:  res_d = op_a ^ op_b;
      3'b111:  res_d = op_a & op_b;
      default: res_d = op_a;  // shifts start from the unshifted operand
    endcase
  end

  always_comb begin
    shifted = res_q;
    case (sop_q)
      2'b00:   shifted = {res_q[WIDTH-2:0], res_q[WIDTH-1]};
      2'b01:   shifted = {res_q[WIDTH-2:0], 1'b0};
      2'b10:   shifted = {res_q[0], res_q[WIDTH-1:1]};
      default: shifted = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      ofl_q   <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      sop_q   <= 2'b00;
    end else begin
      case (state_q)
        SHIFT: begin
          res_q <= shifted;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: ;
      endcase
      // Acceptance in DONE overrides the return to IDLE, giving back-to-back issue.
      if (accept) begin
        sop_q  <= Op[1:0];
        res_q  <= res_d;
        ofl_q  <= ofl_d;
        cout_q <= cout_d;
        if (Op[2] || (cnt_d == '0)) begin
          cnt_q   <= '0;
          state_q <= DONE;
        end else begin
          cnt_q   <= cnt_d;
          state_q <= SHIFT;
        end
      end
    end
  end

endmodule
